mips_mc_control: RTL

Multi-cycle main control FSM for the MIPS datapath. It sequences PC, IR, register file, ALU, memory and the immediate extender across FETCH/DECODE/EXECUTE/MEM/WB steps. It also selects sign- versus zero-extension of the 16-bit immediate. Memory accesses use a ready handshake with a bounded wait; a timeout halts the core.

---
 rtl/mips_mc_control_if.sv | 46 ++++
 rtl/mips_mc_control.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control_if.sv
// -----------------------------------------------------------------------------
// mips_mc_control_if
// Bundles the instruction-field, memory-handshake and datapath-control signals
// exchanged between the multi-cycle control FSM and the rest of the core.
//   opcode, funct, mem_ready : IR fields and memory completion into the control
//   pc_write .. ext_zero     : datapath control strobes/selects out of the control
//   bus_fault, illegal_op    : sticky fault flags
//   state                    : current FSM state encoding (debug)
// Modports: slave = control unit, master = datapath/testbench side.
// -----------------------------------------------------------------------------
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_zero;
    logic       bus_fault;
    logic       illegal_op;
    logic [3:0] state;

    modport slave (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, ext_zero, bus_fault, illegal_op, state
    );

    modport master (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, ext_zero, bus_fault, illegal_op, state
    );
endinterface

// File: rtl/mips_mc_control.sv
// -----------------------------------------------------------------------------
// mips_mc_control
// Multi-cycle MIPS main control FSM (FETCH/DECODE/EXECUTE/MEM/WB). Controls are
// Moore decodes of the state, except ir_write/pc_write in FETCH which follow
// mem_ready. Memory states wait at most MAX_WAIT cycles for mem_ready, then
// raise sticky bus_fault and park in HALT until reset.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; forces all controls low while high
//   bus  : mips_mc_control_if.slave (opcode/funct/mem_ready in, controls out)
// Parameters: MAX_WAIT (1..255), WAIT_W (wait counter width).
// Build option: define ILLEGAL_OP_TRAP_EN to trap unknown opcodes and illegal
// R-type funct codes (illegal_op + HALT); otherwise unknown opcodes are NOPs.
// -----------------------------------------------------------------------------
module mips_mc_control #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    mips_mc_control_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
        S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
        S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11,
        S_HALT = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);

    state_t            r_state, w_next;
    logic [WAIT_W-1:0] r_wait, w_wait_next;
    logic              r_bus_fault, w_set_fault;
    logic              w_mem_state, w_ext_zero_i;
    logic              w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
    logic              w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
    logic              w_ext_zero;
    logic [1:0]        w_alu_src_b, w_alu_op, w_pc_source;

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal_op, w_set_illegal, w_funct_ok;
    assign w_funct_ok = (bus.funct == 6'b100000) || (bus.funct == 6'b100010) ||
                        (bus.funct == 6'b100100) || (bus.funct == 6'b100101) ||
                        (bus.funct == 6'b101010);
`else
    logic w_unused_funct;
    assign w_unused_funct = ^bus.funct;
`endif

    assign w_mem_state  = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);
    assign w_ext_zero_i = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);

    // Next-state selection plus bus-fault/illegal-op detection
    always_comb begin
        w_next      = r_state;
        w_set_fault = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        w_set_illegal = 1'b0;
`endif
        case (r_state)
            S_FETCH:     w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        if (w_funct_ok) begin
                            w_next = S_R_EXEC;
                        end else begin
                            w_next        = S_HALT;
                            w_set_illegal = 1'b1;
                        end
`else
                        w_next = S_R_EXEC;
`endif
                    end
                    OP_BEQ: w_next = S_BRANCH;
                    OP_J:   w_next = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_I_EXEC;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        w_next        = S_HALT;
                        w_set_illegal = 1'b1;
`else
                        w_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM_ADDR:  w_next = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: w_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    w_next = S_R_WB;
            S_R_WB:      w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            S_I_EXEC:    w_next = S_I_WB;
            S_I_WB:      w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_HALT;
        endcase
        // Timeout only when still not ready at the limit; ready at the limit completes.
        if (w_mem_state && !bus.mem_ready && (r_wait == WAIT_MAX)) begin
            w_next      = S_HALT;
            w_set_fault = 1'b1;
        end else begin
            w_set_fault = 1'b0;
        end
    end

    // Wait counter: clear on any state change, count unanswered memory cycles
    always_comb begin
        if (w_next != r_state) begin
            w_wait_next = WAIT_ZERO;
        end else if (w_mem_state && !bus.mem_ready) begin
            w_wait_next = r_wait + WAIT_ONE;
        end else begin
            w_wait_next = r_wait;
        end
    end

    // State, wait counter and sticky bus-fault registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_wait      <= WAIT_ZERO;
            r_bus_fault <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_wait      <= w_wait_next;
            r_bus_fault <= r_bus_fault | w_set_fault;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    // Sticky illegal-opcode flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_op <= 1'b0;
        end else begin
            r_illegal_op <= r_illegal_op | w_set_illegal;
        end
    end
    assign bus.illegal_op = r_illegal_op;
`else
    assign bus.illegal_op = 1'b0;
`endif

    // Moore control decode; FETCH ir_write/pc_write are qualified by mem_ready
    always_comb begin
        w_pc_write = 1'b0; w_pc_write_cond = 1'b0; w_i_or_d = 1'b0;
        w_mem_read = 1'b0; w_mem_write = 1'b0; w_ir_write = 1'b0;
        w_mem_to_reg = 1'b0; w_reg_dst = 1'b0; w_reg_write = 1'b0;
        w_alu_src_a = 1'b0; w_alu_src_b = 2'b00; w_alu_op = 2'b00;
        w_pc_source = 2'b00; w_ext_zero = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            S_DECODE:    w_alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
            end
            S_I_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = 2'b11;
                w_ext_zero  = w_ext_zero_i;
            end
            S_I_WB: begin
                w_reg_write = 1'b1;
                w_ext_zero  = w_ext_zero_i;
            end
            default: w_mem_read = 1'b0;
        endcase
    end

    // Asynchronous reset drops every request immediately, even mid-access.
    assign bus.pc_write      = w_pc_write      & ~rst;
    assign bus.pc_write_cond = w_pc_write_cond & ~rst;
    assign bus.i_or_d        = w_i_or_d        & ~rst;
    assign bus.mem_read      = w_mem_read      & ~rst;
    assign bus.mem_write     = w_mem_write     & ~rst;
    assign bus.ir_write      = w_ir_write      & ~rst;
    assign bus.mem_to_reg    = w_mem_to_reg    & ~rst;
    assign bus.reg_dst       = w_reg_dst       & ~rst;
    assign bus.reg_write     = w_reg_write     & ~rst;
    assign bus.alu_src_a     = w_alu_src_a     & ~rst;
    assign bus.alu_src_b     = w_alu_src_b     & {2{~rst}};
    assign bus.alu_op        = w_alu_op        & {2{~rst}};
    assign bus.pc_source     = w_pc_source     & {2{~rst}};
    assign bus.ext_zero      = w_ext_zero      & ~rst;
    assign bus.bus_fault     = r_bus_fault;
    assign bus.state         = r_state;
endmodule
